// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Pipeline hazard controller for a five-stage MIPS-style pipeline. It
//   handles load-use stalls, HI/LO read-after-multiply/divide stalls, and
//   branch/jump flushes. It also redirects the PC to the exception vector,
//   produces EX-stage operand forwarding selects, and counts the busy cycles
//   of the multiply/divide unit.
//
// Configuration:
//   HAZARD_CTRL_FWD_EN  defined   -> MEM/WB to EX operand forwarding enabled.
//                       undefined -> no forwarding (fwd_a/fwd_b stay 00).
//                                    Any ID source that matches a pending
//                                    MEM write or an EX load stalls instead.
//
// Parameters:
//   MULT_CYCLES  busy cycles a multiply occupies HI/LO (default 12)
//   DIV_CYCLES   busy cycles a divide occupies HI/LO   (default 35)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_rs, id_rt             source registers of the instruction in ID
//   id_mfhilo                ID instruction reads HI or LO
//   br_taken, jump           branch taken / jump decoded in ID
//   exception                exception detected in ID
//   ex_rs, ex_rt             source registers of the instruction in EX
//   ex_mem_read              EX instruction is a load
//   md_start, md_div         multiply/divide issues in EX (md_div: 1 = divide)
//   mem_rd, mem_reg_write    MEM destination register and write enable
//   wb_rd, wb_reg_write      WB destination register and write enable
//   pc_write, if_id_write    PC and IF/ID register enables
//   if_id_flush              clear IF/ID to a NOP
//   id_ex_bubble             insert a NOP into ID/EX
//   except                   PC mux selects the exception vector
//   fwd_a, fwd_b             EX operand source: 00 regfile, 10 MEM, 01 WB
//   md_busy                  HI/LO not yet valid
// ============================================================================
module hazard_ctrl #(
    parameter int MULT_CYCLES = 12,
    parameter int DIV_CYCLES  = 35
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_mfhilo,
    input  logic       br_taken,
    input  logic       jump,
    input  logic       exception,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic       ex_mem_read,
    input  logic       md_start,
    input  logic       md_div,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_bubble,
    output logic       except,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       md_busy
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        RUN      = 1'b0,
        EXC_MASK = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               busy;
    logic               exc_take;
    logic               load_use;
    logic               hilo_haz;
    logic               dep_stall;
    logic               stall;
    logic [1:0]         fwd_a_raw;
    logic [1:0]         fwd_b_raw;

    assign busy = (cnt_q != '0);

    // An exception is only honoured in RUN; the cycle after one is masked so
    // that a fault held for two cycles cannot redirect the PC twice.
    assign exc_take = (state_q == RUN) && exception;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

    // md_start counts as well as md_busy: an mfhi/mflo directly behind the
    // issuing multiply would otherwise read stale HI/LO.
    assign hilo_haz = id_mfhilo && (busy || md_start);

`ifdef HAZARD_CTRL_FWD_EN
    // MEM is checked first so the youngest producer wins over WB.
    function automatic logic [1:0] fwdSel(input logic [4:0] src);
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == src)) begin
            return 2'b10;
        end
        if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == src)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign fwd_a_raw = fwdSel(ex_rs);
    assign fwd_b_raw = fwdSel(ex_rt);
    assign dep_stall = 1'b0;
`else
    // Without forwarding the ID instruction must wait until a pending MEM
    // write has retired. WB needs no check because the register file
    // writes before it reads.
    logic unused_fwd;

    assign fwd_a_raw  = 2'b00;
    assign fwd_b_raw  = 2'b00;
    assign dep_stall  = mem_reg_write && (mem_rd != 5'd0) &&
                        ((mem_rd == id_rs) || (mem_rd == id_rt));
    assign unused_fwd = ^{ex_rs, wb_rd, wb_reg_write};
`endif

    assign stall = load_use || hilo_haz || dep_stall;

    // State register for the exception mask FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and pipeline control. Priority from highest to lowest is
    // reset, exception, stall, branch/jump flush. A branch under a stall
    // simply waits: ID keeps presenting it until the stall clears.
    always_comb begin
        state_d      = state_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        except       = 1'b0;

        case (state_q)
            RUN:      if (exception) state_d = EXC_MASK;
            EXC_MASK: state_d = RUN;
            default:  state_d = RUN;
        endcase

        if (!rst) begin
            if (exc_take) begin
                except       = 1'b1;
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (stall) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end else if (br_taken || jump) begin
                if_id_flush  = 1'b1;
            end
        end
    end

    // Multiply/divide busy counter. A new issue always reloads, which aborts
    // any operation still in flight. The counter otherwise counts down and
    // stops at zero. Exceptions deliberately leave it alone.
    always_comb begin
        cnt_d = cnt_q;
        if (md_start) begin
            cnt_d = md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (busy) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fwd_a   = rst ? 2'b00 : fwd_a_raw;
    assign fwd_b   = rst ? 2'b00 : fwd_b_raw;
    assign md_busy = !rst && busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for hazard_ctrl. A behavioural model tracks the cycle
// of the last multiply/divide issue and the cycle of the last taken
// exception. From these and the current inputs it derives every expected
// output. Directed scenarios are followed by a long randomized run.
// ============================================================================
module tb_hazard_ctrl;

    localparam int MULT = 12;
    localparam int DIV  = 35;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, mem_rd, wb_rd;
    logic       id_mfhilo, br_taken, jump, exception, ex_mem_read;
    logic       md_start, md_div, mem_reg_write, wb_reg_write;
    logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, except;
    logic [1:0] fwd_a, fwd_b;
    logic       md_busy;

    int checks   = 0;
    int failures = 0;

    // Model state: cycle numbers rather than counters.
    int cycleNo   = 0;
    int busyUntil = -1;
    int excCycle  = -100;

    hazard_ctrl #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_mfhilo(id_mfhilo),
        .br_taken(br_taken), .jump(jump), .exception(exception),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
        .md_start(md_start), .md_div(md_div),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .except(except), .fwd_a(fwd_a), .fwd_b(fwd_b), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    // Advance the model at each clock edge using the inputs of the ending cycle.
    always @(posedge clk) begin
        if (rst) begin
            busyUntil = -1;
            excCycle  = -100;
        end else begin
            if (md_start) busyUntil = cycleNo + (md_div ? DIV : MULT);
            if (exception && (cycleNo != excCycle + 1)) excCycle = cycleNo;
        end
        cycleNo++;
    end

    function automatic logic [1:0] expFwd(input logic [4:0] src);
        logic [1:0] r;
        r = 2'b00;
        if (wb_reg_write && wb_rd != 0 && wb_rd == src) r = 2'b01;
        if (mem_reg_write && mem_rd != 0 && mem_rd == src) r = 2'b10;
`ifndef HAZARD_CTRL_FWD_EN
        r = 2'b00;
`endif
        return r;
    endfunction

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, except, fwd_a, fwd_b, md_busy}
    function automatic logic [9:0] expOut();
        logic       busy, masked, luse, hilo, dep, stall;
        logic [4:0] ctl;
        if (rst) return 10'b11000_00_00_0;
        busy   = cycleNo <= busyUntil;
        masked = cycleNo == excCycle + 1;
        luse   = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
        hilo   = id_mfhilo && (busy || md_start);
        dep    = 1'b0;
`ifndef HAZARD_CTRL_FWD_EN
        dep    = mem_reg_write && mem_rd != 0 && (mem_rd == id_rs || mem_rd == id_rt);
`endif
        stall  = luse || hilo || dep;
        if (exception && !masked) ctl = 5'b11111;
        else if (stall)           ctl = 5'b00010;
        else if (br_taken || jump) ctl = 5'b11100;
        else                      ctl = 5'b11000;
        return {ctl, expFwd(ex_rs), expFwd(ex_rt), busy};
    endfunction

    function automatic logic [9:0] gotOut();
        return {pc_write, if_id_write, if_id_flush, id_ex_bubble, except,
                fwd_a, fwd_b, md_busy};
    endfunction

    task automatic clearInputs();
        rst = 0; id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; mem_rd = 0; wb_rd = 0;
        id_mfhilo = 0; br_taken = 0; jump = 0; exception = 0; ex_mem_read = 0;
        md_start = 0; md_div = 0; mem_reg_write = 0; wb_reg_write = 0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clearInputs();
        rst = 1;
        md_start = 1;
        exception = 1;
        @(negedge clk);
        checks++;
        if (gotOut() !== 10'b11000_00_00_0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", gotOut(), 10'b11000_00_00_0);
        end
        nextCycle();
        clearInputs();
        @(negedge clk);
        checks++;
        if (gotOut() !== 10'b11000_00_00_0) begin
            failures++;
            $display("[TB] FAIL after_reset_idle: got %b expected %b", gotOut(), 10'b11000_00_00_0);
        end
        nextCycle();
    endtask

    task automatic test_load_use();
        clearInputs();
        ex_mem_read = 1; ex_rt = 5; id_rs = 5;
        @(negedge clk);
        checks++;
        if ({pc_write, if_id_write, id_ex_bubble} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL load_use_stall: got %b expected 001", {pc_write, if_id_write, id_ex_bubble});
        end
        nextCycle();
        ex_mem_read = 0;
        @(negedge clk);
        checks++;
        if (pc_write !== 1'b1) begin
            failures++;
            $display("[TB] FAIL load_use_release: got %b expected 1", pc_write);
        end
        nextCycle();
        clearInputs();
        ex_mem_read = 1; ex_rt = 0; id_rs = 0;
        @(negedge clk);
        checks++;
        if (pc_write !== 1'b1) begin
            failures++;
            $display("[TB] FAIL load_r0_no_stall: got %b expected 1", pc_write);
        end
        nextCycle();
    endtask

    task automatic test_forwarding();
        logic [1:0] expA;
        clearInputs();
`ifdef HAZARD_CTRL_FWD_EN
        expA = 2'b10;
`else
        expA = 2'b00;
`endif
        mem_rd = 8; wb_rd = 8; mem_reg_write = 1; wb_reg_write = 1; ex_rs = 8;
        @(negedge clk);
        checks++;
        if (fwd_a !== expA) begin
            failures++;
            $display("[TB] FAIL fwd_mem_priority: got %b expected %b", fwd_a, expA);
        end
        nextCycle();
        clearInputs();
        mem_rd = 0; mem_reg_write = 1; wb_rd = 0; wb_reg_write = 1; ex_rt = 0;
        @(negedge clk);
        checks++;
        if (fwd_b !== 2'b00) begin
            failures++;
            $display("[TB] FAIL fwd_r0: got %b expected 00", fwd_b);
        end
        nextCycle();
        clearInputs();
        mem_rd = 3; mem_reg_write = 1; wb_rd = 7; wb_reg_write = 1;
        ex_rs = 7; ex_rt = 3; id_rs = 3;
        @(negedge clk);
        checks++;
        if (gotOut() !== expOut()) begin
            failures++;
            $display("[TB] FAIL fwd_wb_and_mem_dep: got %b expected %b", gotOut(), expOut());
        end
        nextCycle();
    endtask

    task automatic test_md_counter();
        int busyCount;
        clearInputs();
        md_start = 1; md_div = 0;
        @(negedge clk);
        checks++;
        if (md_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL md_issue_cycle: got %b expected 0", md_busy);
        end
        nextCycle();
        clearInputs();
        busyCount = 0;
        for (int i = 0; i < 14; i++) begin
            id_mfhilo = (i == 4) || (i == 12);
            @(negedge clk);
            if (md_busy === 1'b1) busyCount++;
            checks++;
            if (md_busy !== (i < 12)) begin
                failures++;
                $display("[TB] FAIL md_busy_offset%0d: got %b expected %b", i + 1, md_busy, (i < 12));
            end
            if (id_mfhilo) begin
                checks++;
                if (pc_write !== (i >= 12)) begin
                    failures++;
                    $display("[TB] FAIL hilo_stall_offset%0d: got pc_write=%b expected %b", i + 1, pc_write, (i >= 12));
                end
            end
            nextCycle();
        end
        checks++;
        if (busyCount != MULT) begin
            failures++;
            $display("[TB] FAIL md_busy_length: got %0d expected %0d", busyCount, MULT);
        end
        clearInputs();
        id_mfhilo = 1; md_start = 1; md_div = 1;
        @(negedge clk);
        checks++;
        if (pc_write !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hilo_same_cycle_start: got %b expected 0", pc_write);
        end
        nextCycle();
    endtask

    task automatic test_exception();
        clearInputs();
        rst = 1;
        nextCycle();
        clearInputs();
        exception = 1;
        @(negedge clk);
        checks++;
        if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, except} !== 5'b11111) begin
            failures++;
            $display("[TB] FAIL exc_first: got %b expected 11111", {pc_write, if_id_write, if_id_flush, id_ex_bubble, except});
        end
        nextCycle();
        @(negedge clk);
        checks++;
        if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, except} !== 5'b11000) begin
            failures++;
            $display("[TB] FAIL exc_masked: got %b expected 11000", {pc_write, if_id_write, if_id_flush, id_ex_bubble, except});
        end
        nextCycle();
        clearInputs();
        nextCycle();
    endtask

    task automatic test_branch_stall();
        clearInputs();
        ex_mem_read = 1; ex_rt = 5; id_rt = 5; br_taken = 1;
        @(negedge clk);
        checks++;
        if ({pc_write, if_id_flush, id_ex_bubble} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL branch_under_stall: got %b expected 001", {pc_write, if_id_flush, id_ex_bubble});
        end
        nextCycle();
        ex_mem_read = 0;
        @(negedge clk);
        checks++;
        if ({pc_write, if_id_flush, id_ex_bubble} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL branch_after_stall: got %b expected 110", {pc_write, if_id_flush, id_ex_bubble});
        end
        nextCycle();
        clearInputs();
        jump = 1;
        @(negedge clk);
        checks++;
        if (if_id_flush !== 1'b1) begin
            failures++;
            $display("[TB] FAIL jump_flush: got %b expected 1", if_id_flush);
        end
        nextCycle();
    endtask

    task automatic test_reset_mid_op();
        clearInputs();
        md_start = 1; md_div = 1;
        nextCycle();
        clearInputs();
        for (int i = 0; i < 4; i++) nextCycle();
        rst = 1;
        @(negedge clk);
        checks++;
        if (md_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL md_busy_during_rst: got %b expected 0", md_busy);
        end
        nextCycle();
        rst = 0;
        @(negedge clk);
        checks++;
        if (md_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL md_busy_after_rst: got %b expected 0", md_busy);
        end
        nextCycle();
        exception = 1; ex_mem_read = 1; ex_rt = 9; id_rs = 9;
        @(negedge clk);
        checks++;
        if ({except, pc_write, id_ex_bubble} !== 3'b111) begin
            failures++;
            $display("[TB] FAIL exc_over_stall: got %b expected 111", {except, pc_write, id_ex_bubble});
        end
        nextCycle();
        clearInputs();
        nextCycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            rst           = ($urandom_range(99) < 2);
            id_rs         = 5'($urandom_range(3));
            id_rt         = 5'($urandom_range(3));
            ex_rs         = 5'($urandom_range(3));
            ex_rt         = 5'($urandom_range(3));
            mem_rd        = 5'($urandom_range(3));
            wb_rd         = 5'($urandom_range(3));
            ex_mem_read   = ($urandom_range(99) < 30);
            mem_reg_write = ($urandom_range(99) < 50);
            wb_reg_write  = ($urandom_range(99) < 50);
            id_mfhilo     = ($urandom_range(99) < 20);
            br_taken      = ($urandom_range(99) < 15);
            jump          = ($urandom_range(99) < 10);
            exception     = ($urandom_range(99) < 12);
            md_start      = ($urandom_range(99) < 4);
            md_div        = $urandom_range(1) == 1;
            @(negedge clk);
            checks++;
            if (gotOut() !== expOut()) begin
                failures++;
                $display("[TB] FAIL random_cycle%0d: got %b expected %b", n, gotOut(), expOut());
            end
            nextCycle();
        end
        clearInputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forwarding();
        test_md_counter();
        test_exception();
        test_branch_stall();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
